// File: rtl/bypass_network.sv
// bypass_network: multi-source, multi-stage operand forwarding with hazard flags and retire capture
module bypass_network #(
  parameter int XLEN       = 64,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int IDX_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       bubble_i,
  input  logic                       stall_i,
  input  logic [NUM_STAGES-1:0]      stg_valid_i,
  input  logic [NUM_STAGES-1:0]      stg_wr_en_i,
  input  logic [NUM_STAGES-1:0]      stg_ready_i,
  input  logic [NUM_STAGES*IDX_W-1:0] stg_rd_idx_i,
  input  logic [NUM_STAGES*XLEN-1:0] stg_rd_data_i,
  input  logic [NUM_SRC*IDX_W-1:0]   rs_idx_i,
  input  logic [NUM_SRC*XLEN-1:0]    rs_data_i,
  input  logic [NUM_SRC-1:0]         rs_used_i,
  output logic [NUM_SRC*XLEN-1:0]    rs_data_ao,
  output logic [NUM_SRC-1:0]         hazard_ao,
  output logic                       any_hazard_ao,
  output logic [CNT_W-1:0]           hazard_cnt_o
);
  logic waiting;
  assign waiting = bubble_i | stall_i;
  assign any_hazard_ao = |hazard_ao;
  genvar n, s;
  for (n = 0; n < NUM_SRC; n++) begin : g_src
    logic [IDX_W-1:0] idx;
    logic [NUM_STAGES-1:0] m;
    logic [XLEN-1:0] d, cap_val;
    logic h, cap_vld;
    assign idx = rs_idx_i[n*IDX_W +: IDX_W];
    for (s = 0; s < NUM_STAGES; s++) begin : g_stg
      assign m[s] = rs_used_i[n] & stg_valid_i[s] & stg_wr_en_i[s]
                  & (idx == stg_rd_idx_i[s*IDX_W +: IDX_W]) & (idx != '0);
    end
    // Walk oldest to youngest so the youngest match overrides data and hazard.
    always_comb begin
      d = cap_vld ? cap_val : rs_data_i[n*XLEN +: XLEN];
      h = 1'b0;
      for (int k = NUM_STAGES-1; k >= 0; k--) begin
        if (m[k]) begin
          d = stg_rd_data_i[k*XLEN +: XLEN];
          h = ~stg_ready_i[k];
        end
      end
    end
    assign rs_data_ao[n*XLEN +: XLEN] = d;
    assign hazard_ao[n] = h;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cap_vld <= 1'b0;
        cap_val <= '0;
      end else if (waiting && m[NUM_STAGES-1]) begin
        cap_vld <= 1'b1;
        cap_val <= stg_rd_data_i[(NUM_STAGES-1)*XLEN +: XLEN];
      end else if (!waiting) begin
        cap_vld <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hazard_cnt_o <= '0;
    else if (any_hazard_ao && !(&hazard_cnt_o)) hazard_cnt_o <= hazard_cnt_o + 1'b1;
  end
endmodule
